// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit plus the MEM/WB pipeline register.
// An access runs IDLE -> REQ -> (WAIT) -> DONE; stallMem holds the pipe while the access is in flight.
// Optional build macro MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning their offset down.
module mem_stage_lsu #(
   parameter int N  = 32,   // data width, 32 or 64
   parameter int AW = 32    // memory address width, not wider than N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_en,
   input  logic            mem_ready,
   input  logic            valid,
   input  logic [N-1:0]    rdata,
   input  logic [6:0]      cwMEM,
   input  logic [2:0]      funct3,
   input  logic [N-1:0]    wrData_in,
   input  logic [N-1:0]    ALUres,
   input  logic [N-1:0]    NPCin,
   input  logic [N-1:0]    IMMin,
   input  logic [4:0]      Rdest_in,
   output logic            proc_req,
   output logic            we_out,
   output logic [AW-1:0]   addr,
   output logic [N/8-1:0]  be,
   output logic [N-1:0]    wdata,
   output logic [N-1:0]    loadData,
   output logic [N-1:0]    ALUout,
   output logic [N-1:0]    NPCout,
   output logic [N-1:0]    IMMout,
   output logic [4:0]      Rdest_out,
   output logic [2:0]      cwWB,
   output logic            stallMem,
   output logic            misalign
);

   localparam int NB = N / 8;
   localparam int OB = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [NB-1:0]   be_q, be_d;
   logic [N-1:0]    wdata_q, wdata_d;
   logic            we_q, we_d;
   logic            proc_req_q, proc_req_d;
   logic [OB-1:0]   ld_off_q, ld_off_d;
   logic [1:0]      ld_size_q, ld_size_d;
   logic            ld_uns_q, ld_uns_d;
   logic [N-1:0]    ld_buf_q, ld_buf_d;
   logic [2:0]      cwwb_q, cwwb_d;
   logic [N-1:0]    aluout_q, aluout_d;
   logic [N-1:0]    npc_q, npc_d;
   logic [N-1:0]    imm_q, imm_d;
   logic [4:0]      rdest_q, rdest_d;
   logic [N-1:0]    loaddata_q, loaddata_d;

   logic            pending;
   logic            trap;
   logic [1:0]      size_eff;
   logic [OB-1:0]   offset;
   logic [OB-1:0]   low_mask;
   logic [OB-1:0]   eoff;
   logic [NB-1:0]   size_be;
   logic [NB-1:0]   be_calc;
   logic [N-1:0]    wdata_calc;
   logic [N-1:0]    ld_shifted;
   logic [N-1:0]    ld_fmt;
   logic            ld_sign;
   logic [6:0]      wb_bits;
`ifdef MISALIGN_TRAP_EN
   logic            mis;
`endif

   // Decode the incoming access: size, byte offset, lane-aligned byte enables and store data
   always_comb begin
      pending  = cwMEM[4] | cwMEM[3];
      size_eff = funct3[1:0];
      // A dword request on a 32-bit datapath degrades to a word access
      if (N == 32 && funct3[1:0] == 2'b11) size_eff = 2'b10;
      offset = ALUres[OB-1:0];
      // Offset bits that must be zero for the access to be naturally aligned
      for (int i = 0; i < OB; i++) low_mask[i] = (i < int'(size_eff));
      for (int i = 0; i < NB; i++) size_be[i] = (i < (1 << size_eff));
`ifdef MISALIGN_TRAP_EN
      mis  = |(offset & low_mask);
      eoff = offset;
      trap = (state_q == IDLE) & pending & mis;
`else
      eoff = offset & ~low_mask;
      trap = 1'b0;
`endif
      be_calc    = size_be << eoff;
      wdata_calc = wrData_in << {eoff, 3'b000};
   end

   // Format returned read data using the size/offset captured when the request was issued
   always_comb begin
      ld_shifted = rdata >> {ld_off_q, 3'b000};
      case (ld_size_q)
         2'b00:   begin ld_sign = ld_shifted[7];   wb_bits = 7'd8;  end
         2'b01:   begin ld_sign = ld_shifted[15];  wb_bits = 7'd16; end
         2'b10:   begin ld_sign = ld_shifted[31];  wb_bits = 7'd32; end
         default: begin ld_sign = ld_shifted[N-1]; wb_bits = 7'd64; end
      endcase
      for (int i = 0; i < N; i++)
         ld_fmt[i] = (i < int'(wb_bits)) ? ld_shifted[i] : (ld_sign & ~ld_uns_q);
   end

   // Next-state logic for the access FSM, request latches and the MEM/WB register
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      proc_req_d = proc_req_q;
      ld_off_d   = ld_off_q;
      ld_size_d  = ld_size_q;
      ld_uns_d   = ld_uns_q;
      ld_buf_d   = ld_buf_q;
      cwwb_d     = cwwb_q;
      aluout_d   = aluout_q;
      npc_d      = npc_q;
      imm_d      = imm_q;
      rdest_d    = rdest_q;
      loaddata_d = loaddata_q;

      case (state_q)
         IDLE: begin
            if (pending && !trap) begin
               addr_d     = {ALUres[AW-1:OB], {OB{1'b0}}};
               be_d       = be_calc;
               wdata_d    = wdata_calc;
               we_d       = cwMEM[6] | ~cwMEM[5];
               ld_off_d   = eoff;
               ld_size_d  = size_eff;
               ld_uns_d   = funct3[2];
               proc_req_d = 1'b1;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_ready) begin
               proc_req_d = 1'b0;
               if (we_q) begin
                  state_d = DONE;
               end else if (valid) begin
                  ld_buf_d = ld_fmt;
                  state_d  = DONE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (valid) begin
               ld_buf_d = ld_fmt;
               state_d  = DONE;
            end
         end
         DONE: begin
            // Wait for the pipe to advance so the same access is never reissued
            if (pipe_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (pipe_en) begin
         cwwb_d     = trap ? 3'b000 : cwMEM[2:0];
         aluout_d   = ALUres;
         npc_d      = NPCin;
         imm_d      = IMMin;
         rdest_d    = Rdest_in;
         loaddata_d = ld_buf_q;
      end
   end

   // State and output registers; reset abandons any in-flight response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         proc_req_q <= 1'b0;
         ld_off_q   <= '0;
         ld_size_q  <= '0;
         ld_uns_q   <= 1'b0;
         ld_buf_q   <= '0;
         cwwb_q     <= '0;
         aluout_q   <= '0;
         npc_q      <= '0;
         imm_q      <= '0;
         rdest_q    <= '0;
         loaddata_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         proc_req_q <= proc_req_d;
         ld_off_q   <= ld_off_d;
         ld_size_q  <= ld_size_d;
         ld_uns_q   <= ld_uns_d;
         ld_buf_q   <= ld_buf_d;
         cwwb_q     <= cwwb_d;
         aluout_q   <= aluout_d;
         npc_q      <= npc_d;
         imm_q      <= imm_d;
         rdest_q    <= rdest_d;
         loaddata_q <= loaddata_d;
      end
   end

   assign proc_req  = proc_req_q;
   assign we_out    = we_q;
   assign addr      = addr_q;
   assign be        = be_q;
   assign wdata     = wdata_q;
   assign loadData  = loaddata_q;
   assign ALUout    = aluout_q;
   assign NPCout    = npc_q;
   assign IMMout    = imm_q;
   assign Rdest_out = rdest_q;
   assign cwWB      = cwwb_q;
   // Stall starts combinationally on the cycle an access is first seen, then follows REQ/WAIT
   assign stallMem  = ~rst & ((state_q == REQ) | (state_q == WAIT) |
                              ((state_q == IDLE) & pending & ~trap));
`ifdef MISALIGN_TRAP_EN
   assign misalign  = ~rst & trap;
`else
   assign misalign  = 1'b0;
`endif

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning data width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter AW, default 32, meaning memory address width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high, ports named clk and rst.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- pipe_en, in, 1, MEM/WB register enable
- mem_ready, in, 1, memory accepts request
- valid, in, 1, read data valid
- rdata, in, N, memory read data
- cwMEM, in, 7, control word: [6] memWrite, [5] memRead, [4] loadReq, [3] storeReq, [2:0] WB control
- funct3, in, 3, access size [1:0] (00 byte, 01 half, 10 word, 11 dword only when N=64); [2]=1 zero-extend
- wrData_in / ALUres / NPCin / IMMin, in, N each, store data, effective address, PC+4, immediate
- Rdest_in, in, 5, destination register
- proc_req, out, 1, memory request
- we_out, out, 1, write strobe
- addr, out, AW, word-aligned address
- be, out, N/8, byte enables
- wdata, out, N, lane-aligned store data
- loadData / ALUout / NPCout / IMMout, out, N each, MEM/WB registers
- Rdest_out, out, 5, MEM/WB register
- cwWB, out, 3, MEM/WB control
- stallMem, out, 1, pipeline stall
- misalign, out, 1, misaligned-access flag

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT and DONE; an access is pending when cwMEM[4] or cwMEM[3] is 1.
REQ-006 In IDLE with an access pending and aligned, the block SHALL latch addr, be, wdata and we_out (we_out = memWrite OR NOT memRead), assert stallMem combinationally in the same cycle, and enter REQ.
REQ-007 In REQ, proc_req SHALL be 1 and the latched outputs SHALL be held stable until mem_ready=1.
REQ-008 On mem_ready in REQ, a store SHALL go to DONE; a load SHALL go to WAIT, or directly to DONE if valid=1 in the same cycle.
REQ-009 In WAIT, on valid=1 the block SHALL capture the formatted rdata into an internal buffer and enter DONE; valid outside REQ/WAIT SHALL be ignored.
REQ-010 stallMem SHALL be 1 in REQ and WAIT and SHALL be 0 in DONE; DONE SHALL hold until pipe_en=1 and then return to IDLE, so the access is never reissued.
REQ-011 be SHALL equal the size mask (1, 3, 0xF or 0xFF) shifted left by the byte offset ALUres[log2(N/8)-1:0]; wdata SHALL be the store data shifted left by the offset times 8.
REQ-012 addr SHALL equal ALUres[AW-1:0] with the low log2(N/8) bits forced to 0.
REQ-013 Load formatting SHALL shift rdata right by the offset times 8, extract the access size, and sign-extend to N bits when funct3[2]=0 or zero-extend when funct3[2]=1.
REQ-014 When pipe_en=1, cwWB, ALUout, NPCout, IMMout, Rdest_out and loadData SHALL load cwMEM[2:0], ALUres, NPCin, IMMin, Rdest_in and the load buffer respectively, with a one-cycle latency.
REQ-015 An access is misaligned when its byte offset is not a multiple of its size in bytes.

Reset
REQ-016 Assertion of rst SHALL immediately force the state to IDLE and all outputs to 0, including proc_req, stallMem, misalign and every MEM/WB register.
REQ-017 After a reset during REQ or WAIT, the in-flight response SHALL be discarded and no load data SHALL be written.

Configuration
REQ-018 With MISALIGN_TRAP_EN defined, a misaligned pending access in IDLE SHALL set misalign=1 combinationally, issue no request, keep stallMem=0, and register cwWB as 3'b000.
REQ-019 Without MISALIGN_TRAP_EN, misalign SHALL be tied to 0, and the offset bits below the access size SHALL be forced to 0 before the be, wdata and load formatting.

Verification
REQ-020 The bench SHALL cover these directed scenarios (N=32):
- sb with ALUres=0x1003 and wrData_in=0xAB: addr=0x1000, be=4'b1000, wdata=0xAB000000, we_out=1; after mem_ready the FSM passes through DONE with one stallMem=0 cycle.
- lb with ALUres=0x2001 and rdata=0x0000_8000: loadData=0xFFFF_FF80; lbu gives 0x0000_0080.
- lw with mem_ready held 0 for 3 cycles and valid 2 cycles after mem_ready: stallMem=1 throughout, proc_req drops after the accept, and loadData equals rdata.
- mem_ready and valid in the same REQ cycle: the FSM skips WAIT and DONE is reached on the next cycle.
- rst pulsed during WAIT, then valid=1: the FSM stays in IDLE, all outputs are 0, and loadData is unchanged.
- With MISALIGN_TRAP_EN, lw with ALUres=0x3002: misalign=1, proc_req=0, stallMem=0, and cwWB registers 0.
